dp_ram_sync_clr: RTL and testbench
==================================

// Module: dp_ram_sync_clr
// PURPOSE
//  Single-clock simple dual-port RAM (1 write port, 1 read port) for spike/weight buffers.
//  Adds per-byte write masks, a selectable read-during-write mode and 1- or 2-cycle read latency.
//  Reads carry a read_valid flag. An FSM sweeps the whole array to zero after reset or on request.
//  Sits between the core controllers and block RAM. Infers a block RAM plus optional output register.
// PARAMETERS
//  RAM_WIDTH      8  data word width in bits; must be a multiple of BYTE_W
//  ADDR_WIDTH     4  address bits; DEPTH = 2**ADDR_WIDTH words
//  BYTE_W         8  write-mask granularity in bits; NB = RAM_WIDTH/BYTE_W mask lanes
//  RD_LATENCY     1  read latency in cycles, 1 or 2 (2 = extra output register)
//  RDW_MODE       0  same-address read/write in one cycle: 0 = old data, 1 = new data (bypass)
//  CLEAR_ON_RESET 1  1 = run the zero sweep after reset; 0 = go straight to READY
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           synchronous reset, active high
//  write_allow  in   1           write request, sampled at posedge
//  write_addr   in   ADDR_WIDTH  write address
//  write_data   in   RAM_WIDTH   write data
//  write_mask   in   NB          per-lane write enable; lane k = bits [k*BYTE_W +: BYTE_W]
//  read_allow   in   1           read request, sampled at posedge
//  read_addr    in   ADDR_WIDTH  read address
//  read_data    out  RAM_WIDTH   read data; holds its last value when no read completes
//  read_valid   out  1           1-cycle pulse; read_data is valid this cycle
//  clear_req    in   1           request a full zero sweep
//  ready        out  1           1 = READY; requests are accepted
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - read_data=0, read_valid=0 and the whole read pipeline is flushed.
//   - clear address = 0. State = CLEAR if CLEAR_ON_RESET=1, else READY.
//   - ready=0 while in CLEAR. Memory contents are not reset directly.
//  FSM states: CLEAR, READY
//   - CLEAR: each cycle writes all-zero to clr_addr, then clr_addr+1.
//     After writing address DEPTH-1, go to READY the next cycle. The sweep takes exactly DEPTH cycles.
//   - READY: clear_req=1 -> CLEAR next cycle with clr_addr=0.
//     A write or read sampled in that same cycle is still performed.
//   - clear_req in CLEAR is ignored; the sweep does not restart.
//   - rst during CLEAR restarts the sweep from address 0.
//  Request gating
//   - write_allow and read_allow are ignored while ready=0: no write, no read_valid.
//   - Reads accepted before entering CLEAR drain through the pipeline normally.
//  Write
//   - At the posedge where write_allow=1 and ready=1, lanes with write_mask[k]=1 are updated.
//   - Other lanes keep their value. write_mask=0 is a no-op.
//  Read
//   - read_allow=1 and ready=1 at edge N -> read_data/read_valid valid after edge N+RD_LATENCY.
//   - read_valid is high for exactly one cycle per accepted read. Back-to-back reads give full throughput.
//  Read-during-write, same address, same edge
//   - RDW_MODE=0: returns the pre-write word.
//   - RDW_MODE=1: masked lanes return new data, unmasked lanes return old data.
//   - Different addresses never interact.
//  Address arithmetic: clr_addr is ADDR_WIDTH bits; sweep ends on the terminal-count compare, not on wrap.
//  Illegal parameters (RAM_WIDTH % BYTE_W != 0, RD_LATENCY not 1 or 2): elaboration-time $error.
// TESTING
//  T1 Reset sweep: rst 1 cycle, CLEAR_ON_RESET=1, DEPTH=16
//     -> ready=0 for 16 cycles then 1; reading addresses 0..15 returns 0x00.
//  T2 Latency: RD_LATENCY=1 and 2. Write 0xA5@3, then read@3 at edge N
//     -> read_valid=1 and read_data=0xA5 after edge N+1 (resp. N+2); read_valid low otherwise.
//  T3 Byte mask: RAM_WIDTH=16. Write 0x1234@5 mask 11, then 0xABCD@5 mask 01 -> read@5 returns 0x12CD.
//  T4 RDW: memory@7=0x11. Same edge: write 0x22@7 and read@7
//     -> RDW_MODE=0 returns 0x11, RDW_MODE=1 returns 0x22; the next read@7 returns 0x22.
//  T5 Runtime clear: fill with 0xFF. Read@2 and clear_req in the same cycle
//     -> that read returns 0xFF with read_valid; reads during CLEAR produce no read_valid;
//     ready returns after 16 cycles; all words read 0.
//  T6 Reset mid-sweep: rst at sweep cycle 9
//     -> ready stays 0 a further 16 cycles; reads in flight are flushed (no read_valid).

Source files
------------

// File: rtl/dp_ram_sync_clr.sv
// rtl/dp_ram_sync_clr.sv - simple dual-port RAM with byte masks, RDW mode, 1/2-cycle read latency and zero sweep
module dp_ram_sync_clr #(
  parameter int RAM_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int BYTE_W         = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = RAM_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_allow,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [RAM_WIDTH-1:0]  write_data,
  input  logic [NB-1:0]         write_mask,
  input  logic                  read_allow,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [RAM_WIDTH-1:0]  read_data,
  output logic                  read_valid,
  input  logic                  clear_req,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (RAM_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("dp_ram_sync_clr: RAM_WIDTH must be a multiple of BYTE_W");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("dp_ram_sync_clr: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {S_CLEAR, S_READY} state_e;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_READY;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      S_READY: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  assign ready = (state_q == S_READY);

  logic user_wr, rd_en;
  assign user_wr = write_allow && ready && !rst;
  assign rd_en   = read_allow && ready && !rst;

  // The sweep borrows the single write port, so the RAM keeps one write path.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_WIDTH-1:0]  wr_data;
  logic [NB-1:0]         wr_mask;

  always_comb begin
    wr_en   = user_wr;
    wr_addr = write_addr;
    wr_data = write_data;
    wr_mask = write_mask;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = '0;
      wr_mask = '1;
    end
  end

  logic [RAM_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_mask[k]) begin
          mem_q[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  logic [RAM_WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = mem_q[read_addr];
    if (RDW_MODE != 0 && user_wr && (write_addr == read_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (write_mask[k]) begin
          rd_word[k*BYTE_W +: BYTE_W] = write_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  logic                 s1_valid_q;
  logic [RAM_WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                 out_valid_q;
    logic [RAM_WIDTH-1:0] out_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= s1_data_q;
        end
      end
    end

    assign read_data  = out_data_q;
    assign read_valid = out_valid_q;
  end else begin : g_lat1
    assign read_data  = s1_data_q;
    assign read_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_dp_ram_sync_clr.sv
// tb/tb_dp_ram_sync_clr.sv - directed bench for dp_ram_sync_clr across three parameter sets
module tb_dp_ram_sync_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wa = 1'b0, ra = 1'b0, clr = 1'b0;
  logic [3:0]  waddr = '0, raddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wmask = '0;

  logic [7:0]  rd0, rd2;
  logic [15:0] rd1;
  logic        rv0, rv1, rv2, rdy0, rdy1, rdy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: 8-bit, latency 1, old-data RDW
  dp_ram_sync_clr #(.RAM_WIDTH(8), .ADDR_WIDTH(4), .BYTE_W(8), .RD_LATENCY(1),
                    .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .write_allow(wa), .write_addr(waddr), .write_data(wdata[7:0]),
    .write_mask(wmask[0:0]), .read_allow(ra), .read_addr(raddr), .read_data(rd0),
    .read_valid(rv0), .clear_req(clr), .ready(rdy0));

  // dut1: 16-bit two lanes, latency 2, bypass RDW
  dp_ram_sync_clr #(.RAM_WIDTH(16), .ADDR_WIDTH(4), .BYTE_W(8), .RD_LATENCY(2),
                    .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .write_allow(wa), .write_addr(waddr), .write_data(wdata),
    .write_mask(wmask), .read_allow(ra), .read_addr(raddr), .read_data(rd1),
    .read_valid(rv1), .clear_req(clr), .ready(rdy1));

  // dut2: 8-bit, latency 1, bypass RDW, no sweep after reset
  dp_ram_sync_clr #(.RAM_WIDTH(8), .ADDR_WIDTH(4), .BYTE_W(8), .RD_LATENCY(1),
                    .RDW_MODE(1), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst(rst), .write_allow(wa), .write_addr(waddr), .write_data(wdata[7:0]),
    .write_mask(wmask[0:0]), .read_allow(ra), .read_addr(raddr), .read_data(rd2),
    .read_valid(rv2), .clear_req(clr), .ready(rdy2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    wa = 1'b1; waddr = a; wdata = d; wmask = m;
    step();
    wa = 1'b0;
  endtask

  function automatic logic [15:0] pat(input logic [3:0] a);
    return {4'hC, a, 4'h3, ~a};
  endfunction

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", rdy0); end
    total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b want=0", rv0); end
    total++; if (rd0 !== 8'h00) begin bad++; $display("FAIL reset_data0 got=%h want=00", rd0); end
    total++; if ({rv1, rd1} !== 17'h0) begin bad++; $display("FAIL reset_dut1 got=%b/%h want=0/0000", rv1, rd1); end
    total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL reset_noclear_ready got=%b want=1", rdy2); end
    n = 0;
    while (!rdy0 && n < 40) begin
      n++;
      step();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL reset_sweep_cycles got=%0d want=16", n); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready1_after got=%b want=1", rdy1); end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 18; i++) begin
      ra = (i < 16); raddr = 4'(i);
      step();
      total++; if (rv0 !== (i < 16)) begin bad++; $display("FAIL zero_valid0[%0d] got=%b want=%b", i, rv0, (i < 16)); end
      total++; if (rv1 !== (i >= 1 && i <= 16)) begin bad++; $display("FAIL zero_valid1[%0d] got=%b", i, rv1); end
      if (i < 16) begin
        total++; if (rd0 !== 8'h00) begin bad++; $display("FAIL zero_data0[%0d] got=%h want=00", i, rd0); end
      end
      if (i >= 1 && i <= 16) begin
        total++; if (rd1 !== 16'h0000) begin bad++; $display("FAIL zero_data1[%0d] got=%h want=0000", i - 1, rd1); end
      end
    end
    ra = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    for (int i = 0; i < 16; i++) begin
      wa = 1'b1; waddr = 4'(i); wdata = pat(4'(i)); wmask = 2'b11;
      step();
    end
    wa = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ra = (i < 16); raddr = 4'(15 - i);
      step();
      if (i < 16) begin
        e = pat(4'(15 - i));
        total++; if (rv0 !== 1'b1 || rd0 !== e[7:0]) begin bad++; $display("FAIL b2b_dut0[%0d] got=%b/%h want=1/%h", i, rv0, rd0, e[7:0]); end
      end
      if (i >= 1 && i <= 16) begin
        e = pat(4'(16 - i));
        total++; if (rv1 !== 1'b1 || rd1 !== e) begin bad++; $display("FAIL b2b_dut1[%0d] got=%b/%h want=1/%h", i, rv1, rd1, e); end
      end
    end
    ra = 1'b0;
  endtask

  task automatic test_latency();
    do_write(4'd3, 16'h00A5, 2'b11);
    ra = 1'b1; raddr = 4'd3;
    step();
    ra = 1'b0;
    total++; if (rv0 !== 1'b1 || rd0 !== 8'hA5) begin bad++; $display("FAIL lat1_edge1 got=%b/%h want=1/a5", rv0, rd0); end
    total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL lat2_early got=%b want=0", rv1); end
    step();
    total++; if (rv0 !== 1'b0 || rd0 !== 8'hA5) begin bad++; $display("FAIL lat1_hold got=%b/%h want=0/a5", rv0, rd0); end
    total++; if (rv1 !== 1'b1 || rd1 !== 16'h00A5) begin bad++; $display("FAIL lat2_edge2 got=%b/%h want=1/00a5", rv1, rd1); end
    step();
    total++; if (rv1 !== 1'b0 || rd1 !== 16'h00A5) begin bad++; $display("FAIL lat2_hold got=%b/%h want=0/00a5", rv1, rd1); end
  endtask

  task automatic test_byte_mask();
    do_write(4'd5, 16'h1234, 2'b11);
    do_write(4'd5, 16'hABCD, 2'b01);
    do_write(4'd5, 16'hFFFF, 2'b00);
    ra = 1'b1; raddr = 4'd5;
    step();
    ra = 1'b0;
    total++; if (rd0 !== 8'hCD) begin bad++; $display("FAIL mask_dut0 got=%h want=cd", rd0); end
    step();
    total++; if (rd1 !== 16'h12CD) begin bad++; $display("FAIL mask_dut1 got=%h want=12cd", rd1); end
  endtask

  task automatic test_rdw();
    do_write(4'd7, 16'h0011, 2'b11);
    wa = 1'b1; waddr = 4'd7; wdata = 16'h0022; wmask = 2'b11;
    ra = 1'b1; raddr = 4'd7;
    step();
    wa = 1'b0; ra = 1'b0;
    total++; if (rd0 !== 8'h11) begin bad++; $display("FAIL rdw_old got=%h want=11", rd0); end
    total++; if (rd2 !== 8'h22) begin bad++; $display("FAIL rdw_new8 got=%h want=22", rd2); end
    step();
    total++; if (rd1 !== 16'h0022) begin bad++; $display("FAIL rdw_new16 got=%h want=0022", rd1); end
    ra = 1'b1;
    step();
    ra = 1'b0;
    total++; if (rd0 !== 8'h22) begin bad++; $display("FAIL rdw_after0 got=%h want=22", rd0); end
    step();
    total++; if (rd1 !== 16'h0022) begin bad++; $display("FAIL rdw_after1 got=%h want=0022", rd1); end
    wa = 1'b1; wdata = 16'hBEEF; wmask = 2'b01; ra = 1'b1;
    step();
    wa = 1'b0; ra = 1'b0;
    total++; if (rd0 !== 8'h22) begin bad++; $display("FAIL rdw_part_old got=%h want=22", rd0); end
    total++; if (rd2 !== 8'hEF) begin bad++; $display("FAIL rdw_part_new8 got=%h want=ef", rd2); end
    step();
    total++; if (rd1 !== 16'h00EF) begin bad++; $display("FAIL rdw_part_lanes got=%h want=00ef", rd1); end
  endtask

  task automatic test_runtime_clear();
    int n, n0, n1;
    for (int i = 0; i < 16; i++) begin
      wa = 1'b1; waddr = 4'(i); wdata = 16'hFFFF; wmask = 2'b11;
      step();
    end
    wa = 1'b0;
    ra = 1'b1; raddr = 4'd2; clr = 1'b1;
    step();
    total++; if (rv0 !== 1'b1 || rd0 !== 8'hFF) begin bad++; $display("FAIL clr_read_before got=%b/%h want=1/ff", rv0, rd0); end
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL clr_ready_drop got=%b want=0", rdy0); end
    n = 0; n0 = 0; n1 = 0;
    while (!rdy0 && n < 40) begin
      n++;
      step();
      if (rv0) n0++;
      if (rv1) begin
        n1++;
        total++; if (rd1 !== 16'hFFFF) begin bad++; $display("FAIL clr_drain_data got=%h want=ffff", rd1); end
      end
    end
    ra = 1'b0; clr = 1'b0;
    total++; if (n !== 16) begin bad++; $display("FAIL clr_sweep_cycles got=%0d want=16", n); end
    total++; if (n0 !== 0) begin bad++; $display("FAIL clr_reads_ignored got=%0d want=0", n0); end
    total++; if (n1 !== 1) begin bad++; $display("FAIL clr_drain_count got=%0d want=1", n1); end
  endtask

  task automatic test_reset_mid_sweep();
    int n, nv;
    do_write(4'd3, 16'h00A5, 2'b11);
    ra = 1'b1; raddr = 4'd3;
    step();
    ra = 1'b0;
    total++; if (rv0 !== 1'b1 || rd0 !== 8'hA5) begin bad++; $display("FAIL mid_pre_read got=%b/%h want=1/a5", rv0, rd0); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rv1 !== 1'b0 || rd1 !== 16'h0000) begin bad++; $display("FAIL mid_flush got=%b/%h want=0/0000", rv1, rd1); end
    total++; if (rd0 !== 8'h00) begin bad++; $display("FAIL mid_rst_data0 got=%h want=00", rd0); end
    ra = 1'b1;
    nv = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (rv0 || rv1 || rdy0) nv++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (!rdy0 && n < 40) begin
      n++;
      step();
      if (rv0 || rv1) nv++;
    end
    ra = 1'b0;
    total++; if (nv !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", nv); end
    total++; if (n !== 16) begin bad++; $display("FAIL mid_restart_cycles got=%0d want=16", n); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_back_to_back();
    test_latency();
    test_byte_mask();
    test_rdw();
    test_runtime_clear();
    test_all_zero();
    test_reset_mid_sweep();
    test_all_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
